// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } dm_state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lo;
      SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic sign, input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: load_extend = {{24{sign & b[7]}}, b};
      SZ_HALF: load_extend = {{16{sign & h[15]}}, h};
      SZ_WORD: load_extend = word;
      default: load_extend = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane datapath: store merge into the old word and load extraction.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  lo,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [3:0]  mask_s;
  logic [31:0] shifted_s;

  // Right-aligned store data is moved onto its lanes; unselected bytes keep the old word.
  always_comb begin
    mask_s    = lane_mask(size, lo);
    shifted_s = wdata << {lo, 3'b000};
    merged    = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask_s[i]) merged[i*8 +: 8] = shifted_s[i*8 +: 8];
      else           merged[i*8 +: 8] = old_word[i*8 +: 8];
    end
    rdata = load_extend(old_word, size, sign, lo);
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready requests, programmable wait states,
// byte-lane stores and extended loads against a word-organised array.
module dm_responder
  import dm_pkg::*;
#(
  parameter int          DEPTH     = 3072,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dm_state_e   state_r, state_nx_s;
  logic [3:0]  cnt_r, cnt_nx_s;
  logic        req_ready_s, hs_s, commit_s;
  logic        we_r, sign_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r, pc_r;
  logic [31:0] mem_r [DEPTH];
  logic        rsp_valid_r, rsp_err_r;
  logic [31:0] rsp_rdata_r;
  logic        borrow_s, err_s;
  logic [31:0] off_s, idx_s, old_word_s, merged_s, load_s;
  logic        unused_s;

  assign hs_s     = req_valid & req_ready_s;
  assign commit_s = (state_r == ST_BUSY) && (cnt_r == 4'd0);
  // pc is carried with the request for debug visibility only
  assign unused_s = ^{pc_r, off_s[1:0]};

  // FSM state and wait-state counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state: accept, count down the wait states, then respond for one cycle.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (hs_s) begin
          state_nx_s = ST_BUSY;
          cnt_nx_s   = LAT_M1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == 4'd0) state_nx_s = ST_RESP;
        else               cnt_nx_s   = cnt_r - 4'd1;
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // Ready is withheld only while the wait states run.
  always_comb begin
    if (state_r == ST_BUSY) req_ready_s = 1'b0;
    else                    req_ready_s = 1'b1;
  end

  // Address decode and legality of the latched request.
  always_comb begin
    {borrow_s, off_s} = {1'b0, addr_r} - {1'b0, ADDR_BASE};
    idx_s = {2'b00, off_s[31:2]};
    if (borrow_s || (idx_s >= 32'(DEPTH))) begin
      err_s = 1'b1;
    end else begin
      case (size_r)
        SZ_BYTE: err_s = 1'b0;
        SZ_HALF: err_s = addr_r[0];
        SZ_WORD: err_s = (addr_r[1:0] != 2'b00);
        default: err_s = 1'b1;
      endcase
    end
    if (err_s) old_word_s = 32'h0000_0000;
    else       old_word_s = mem_r[idx_s[AW-1:0]];
  end

  dm_lane_unit u_lane (
    .old_word (old_word_s),
    .wdata    (wdata_r),
    .size     (size_r),
    .sign     (sign_r),
    .lo       (addr_r[1:0]),
    .merged   (merged_s),
    .rdata    (load_s)
  );

  // Request latch, array commit and registered response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 32'h0000_0000;
      we_r        <= 1'b0;
      size_r      <= 2'b00;
      sign_r      <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      pc_r        <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      if (hs_s) begin
        we_r    <= req_we;
        size_r  <= req_size;
        sign_r  <= req_sign;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        pc_r    <= req_pc;
      end
      rsp_valid_r <= commit_s;
      if (commit_s) begin
        rsp_err_r   <= err_s;
        rsp_rdata_r <= (err_s || we_r) ? 32'h0000_0000 : load_s;
        if (we_r && !err_s) mem_r[idx_s[AW-1:0]] <= merged_s;
      end
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule
